mm2_load_unit: RTL and testbench

- Memory-stage-2 datapath/control, directly downstream of the mm1→mm2 pipeline register.
- Collects the data-memory response for loads issued in mm1, then aligns and sign/zero-extends the data.
- Completed results go to a registered writeback output with valid/ready handshake; stalls upstream while a response or the output slot is outstanding.
- Absorbs in-flight responses of flushed loads.

---
 rtl/mm2_load_unit_if.sv | 29 ++
 rtl/mm2_load_unit.sv | 157 +++++++++++++++
 tb/tb_mm2_load_unit.sv | 381 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mm2_load_unit_if.sv
// Writeback bus from mm2 to the writeback stage: registered result slot with valid/ready.
interface mm2_load_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            wb_valid;
    logic            wb_ready;
    logic [4:0]      wb_reg_d;
    logic            wb_wen;
    logic            wb_excp;
    logic [XLEN-1:0] wb_data;

    modport master (
        output wb_valid,
        output wb_reg_d,
        output wb_wen,
        output wb_excp,
        output wb_data,
        input  wb_ready
    );

    modport slave (
        input  wb_valid,
        input  wb_reg_d,
        input  wb_wen,
        input  wb_excp,
        input  wb_data,
        output wb_ready
    );
endinterface

// File: rtl/mm2_load_unit.sv
// Memory stage 2: collects load responses, aligns/extends them and registers the writeback result.
// Optional load-stall performance counter enabled by defining MM2_PERF_CNT_EN.
module mm2_load_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            mm2_valid,
    input  logic            mm2_excp,
    input  logic            mm2_mm_re,
    input  logic [1:0]      mm2_mm_access_sz,
    input  logic [1:0]      mm2_mm_addr_lo,
    input  logic            mm2_load_unsigned,
    input  logic [XLEN-1:0] mm2_exe_out,
    input  logic [4:0]      mm2_reg_d,
    input  logic            mm2_reg_d_wen,
    input  logic            dm_rvalid,
    input  logic [XLEN-1:0] dm_rdata,
    output logic            stall_req,
    output logic [31:0]     perf_load_stall_cnt,
    mm2_load_unit_if.master wb
);

    typedef enum logic [1:0] {StIdle, StWait, StHold, StDrain} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] buf_q, buf_d;
    logic            wb_valid_q, wb_wen_q, wb_excp_q;
    logic [4:0]      wb_reg_d_q;
    logic [XLEN-1:0] wb_data_q;

    logic            out_free, is_ld, complete;
    logic [XLEN-1:0] cpl_data, ld_data;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;

    assign out_free = !wb_valid_q || wb.wb_ready;
    assign is_ld    = mm2_valid && mm2_mm_re && !mm2_excp && !flush;

    assign ld_byte = dm_rdata[{mm2_mm_addr_lo, 3'b000} +: 8];
    assign ld_half = dm_rdata[{mm2_mm_addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        ld_data = dm_rdata;
        case (mm2_mm_access_sz)
            2'b00: ld_data = mm2_load_unsigned ? {{(XLEN-8){1'b0}}, ld_byte}
                                               : {{(XLEN-8){ld_byte[7]}}, ld_byte};
            2'b01: ld_data = mm2_load_unsigned ? {{(XLEN-16){1'b0}}, ld_half}
                                               : {{(XLEN-16){ld_half[15]}}, ld_half};
            default: ld_data = dm_rdata;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        complete  = 1'b0;
        cpl_data  = mm2_exe_out;
        stall_req = 1'b0;
        case (state_q)
            StIdle: begin
                stall_req = (is_ld && !(dm_rvalid && out_free)) || (mm2_valid && !out_free);
                if (is_ld) begin
                    if (dm_rvalid && out_free) begin
                        complete = 1'b1;
                        cpl_data = ld_data;
                    end else if (dm_rvalid) begin
                        buf_d   = ld_data;
                        state_d = StHold;
                    end else begin
                        state_d = StWait;
                    end
                end else if (mm2_valid && !flush && out_free) begin
                    complete = 1'b1;
                end
            end
            StWait: begin
                stall_req = !(dm_rvalid && out_free);
                if (flush) begin
                    state_d = dm_rvalid ? StIdle : StDrain;
                end else if (dm_rvalid && out_free) begin
                    complete = 1'b1;
                    cpl_data = ld_data;
                    state_d  = StIdle;
                end else if (dm_rvalid) begin
                    buf_d   = ld_data;
                    state_d = StHold;
                end
            end
            StHold: begin
                stall_req = !out_free;
                if (flush) begin
                    state_d = StIdle;
                end else if (out_free) begin
                    complete = 1'b1;
                    cpl_data = buf_q;
                    state_d  = StIdle;
                end
            end
            StDrain: begin
                stall_req = 1'b1;
                if (dm_rvalid) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // A flush releases the pipeline, but a drain must still swallow the stale response.
        if (flush && state_q != StDrain) stall_req = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            buf_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_wen_q   <= 1'b0;
            wb_excp_q  <= 1'b0;
            wb_reg_d_q <= '0;
            wb_data_q  <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            if (complete) begin
                wb_valid_q <= 1'b1;
                wb_reg_d_q <= mm2_reg_d;
                wb_excp_q  <= mm2_excp;
                wb_wen_q   <= mm2_reg_d_wen && !mm2_excp;
                wb_data_q  <= cpl_data;
            end else if (wb.wb_ready) begin
                wb_valid_q <= 1'b0;
            end
        end
    end

    assign wb.wb_valid = wb_valid_q;
    assign wb.wb_reg_d = wb_reg_d_q;
    assign wb.wb_wen   = wb_wen_q;
    assign wb.wb_excp  = wb_excp_q;
    assign wb.wb_data  = wb_data_q;

`ifdef MM2_PERF_CNT_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else if (state_q != StIdle) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_load_stall_cnt = perf_q;
`else
    assign perf_load_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_mm2_load_unit.sv
// Directed self-checking bench for mm2_load_unit.
module tb_mm2_load_unit;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        mm2_valid;
    logic        mm2_excp;
    logic        mm2_mm_re;
    logic [1:0]  mm2_mm_access_sz;
    logic [1:0]  mm2_mm_addr_lo;
    logic        mm2_load_unsigned;
    logic [31:0] mm2_exe_out;
    logic [4:0]  mm2_reg_d;
    logic        mm2_reg_d_wen;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    logic        stall_req;
    logic [31:0] perf_load_stall_cnt;

    int checks = 0;
    int errors = 0;

    mm2_load_unit_if #(.XLEN(32)) wb_if ();

    mm2_load_unit #(.XLEN(32)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .flush               (flush),
        .mm2_valid           (mm2_valid),
        .mm2_excp            (mm2_excp),
        .mm2_mm_re           (mm2_mm_re),
        .mm2_mm_access_sz    (mm2_mm_access_sz),
        .mm2_mm_addr_lo      (mm2_mm_addr_lo),
        .mm2_load_unsigned   (mm2_load_unsigned),
        .mm2_exe_out         (mm2_exe_out),
        .mm2_reg_d           (mm2_reg_d),
        .mm2_reg_d_wen       (mm2_reg_d_wen),
        .dm_rvalid           (dm_rvalid),
        .dm_rdata            (dm_rdata),
        .stall_req           (stall_req),
        .perf_load_stall_cnt (perf_load_stall_cnt),
        .wb                  (wb_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge; inputs change and outputs are sampled here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush             = 1'b0;
        mm2_valid         = 1'b0;
        mm2_excp          = 1'b0;
        mm2_mm_re         = 1'b0;
        mm2_mm_access_sz  = 2'b10;
        mm2_mm_addr_lo    = 2'b00;
        mm2_load_unsigned = 1'b0;
        mm2_exe_out       = 32'h0;
        mm2_reg_d         = 5'd0;
        mm2_reg_d_wen     = 1'b0;
        dm_rvalid         = 1'b0;
        dm_rdata          = 32'h0;
        wb_if.wb_ready    = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        #1;
        checks++;
        if (wb_if.wb_valid !== 1'b0 || wb_if.wb_wen !== 1'b0 || wb_if.wb_excp !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: valid=%b wen=%b excp=%b, want 0 0 0",
                     wb_if.wb_valid, wb_if.wb_wen, wb_if.wb_excp);
        end
        checks++;
        if (wb_if.wb_data !== 32'h0 || wb_if.wb_reg_d !== 5'd0) begin
            errors++;
            $display("FAIL reset_data: data=%h reg_d=%0d, want 0 0", wb_if.wb_data, wb_if.wb_reg_d);
        end
        checks++;
        if (stall_req !== 1'b0 || perf_load_stall_cnt !== 32'h0) begin
            errors++;
            $display("FAIL reset_stall: stall=%b perf=%0d, want 0 0", stall_req, perf_load_stall_cnt);
        end
    endtask

    task automatic test_alu();
        mm2_valid     = 1'b1;
        mm2_exe_out   = 32'h1234;
        mm2_reg_d     = 5'd5;
        mm2_reg_d_wen = 1'b1;
        #1;
        checks++;
        if (stall_req !== 1'b0) begin
            errors++;
            $display("FAIL alu_stall: got %b want 0", stall_req);
        end
        step();
        mm2_valid = 1'b0;
        checks++;
        if (wb_if.wb_valid !== 1'b1 || wb_if.wb_data !== 32'h1234 || wb_if.wb_wen !== 1'b1 ||
            wb_if.wb_reg_d !== 5'd5 || wb_if.wb_excp !== 1'b0) begin
            errors++;
            $display("FAIL alu_wb: valid=%b data=%h wen=%b rd=%0d excp=%b, want 1 1234 1 5 0",
                     wb_if.wb_valid, wb_if.wb_data, wb_if.wb_wen, wb_if.wb_reg_d, wb_if.wb_excp);
        end
        step();
        checks++;
        if (wb_if.wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL alu_retire: wb_valid=%b want 0", wb_if.wb_valid);
        end
    endtask

    task automatic test_load_byte();
        mm2_valid        = 1'b1;
        mm2_mm_re        = 1'b1;
        mm2_mm_access_sz = 2'b00;
        mm2_mm_addr_lo   = 2'd3;
        mm2_reg_d        = 5'd7;
        mm2_reg_d_wen    = 1'b1;
        dm_rvalid        = 1'b1;
        dm_rdata         = 32'h80FF_FFFF;
        #1;
        checks++;
        if (stall_req !== 1'b0) begin
            errors++;
            $display("FAIL ldb_stall: got %b want 0", stall_req);
        end
        step();
        mm2_load_unsigned = 1'b1;
        checks++;
        if (wb_if.wb_valid !== 1'b1 || wb_if.wb_data !== 32'hFFFF_FF80) begin
            errors++;
            $display("FAIL ldb_signed: valid=%b data=%h want 1 ffffff80",
                     wb_if.wb_valid, wb_if.wb_data);
        end
        step();
        checks++;
        if (wb_if.wb_valid !== 1'b1 || wb_if.wb_data !== 32'h0000_0080) begin
            errors++;
            $display("FAIL ldbu_unsigned: valid=%b data=%h want 1 00000080",
                     wb_if.wb_valid, wb_if.wb_data);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_load_wait();
        mm2_valid        = 1'b1;
        mm2_mm_re        = 1'b1;
        mm2_mm_access_sz = 2'b01;
        mm2_mm_addr_lo   = 2'd2;
        mm2_reg_d        = 5'd8;
        mm2_reg_d_wen    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (stall_req !== 1'b1 || wb_if.wb_valid !== 1'b0) begin
                errors++;
                $display("FAIL ldh_wait_cyc%0d: stall=%b wb_valid=%b want 1 0",
                         i, stall_req, wb_if.wb_valid);
            end
            step();
        end
        dm_rvalid = 1'b1;
        dm_rdata  = 32'h8001_0000;
        #1;
        checks++;
        if (stall_req !== 1'b0) begin
            errors++;
            $display("FAIL ldh_resp_stall: got %b want 0", stall_req);
        end
        step();
        idle_inputs();
        checks++;
        if (wb_if.wb_valid !== 1'b1 || wb_if.wb_data !== 32'hFFFF_8001 || wb_if.wb_reg_d !== 5'd8) begin
            errors++;
            $display("FAIL ldh_data: valid=%b data=%h rd=%0d want 1 ffff8001 8",
                     wb_if.wb_valid, wb_if.wb_data, wb_if.wb_reg_d);
        end
        checks++;
`ifdef MM2_PERF_CNT_EN
        if (perf_load_stall_cnt !== 32'd3) begin
            errors++;
            $display("FAIL perf_cnt: got %0d want 3", perf_load_stall_cnt);
        end
`else
        if (perf_load_stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL perf_cnt_off: got %0d want 0", perf_load_stall_cnt);
        end
`endif
        step();
    endtask

    task automatic test_hold();
        wb_if.wb_ready = 1'b0;
        mm2_valid      = 1'b1;
        mm2_exe_out    = 32'h0000_AAAA;
        mm2_reg_d      = 5'd3;
        mm2_reg_d_wen  = 1'b1;
        step();
        mm2_mm_re        = 1'b1;
        mm2_mm_access_sz = 2'b10;
        mm2_reg_d        = 5'd9;
        dm_rvalid        = 1'b1;
        dm_rdata         = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (stall_req !== 1'b1 || wb_if.wb_data !== 32'h0000_AAAA) begin
            errors++;
            $display("FAIL hold_enter: stall=%b data=%h want 1 0000aaaa", stall_req, wb_if.wb_data);
        end
        step();
        dm_rvalid = 1'b0;
        dm_rdata  = 32'h0;
        #1;
        checks++;
        if (stall_req !== 1'b1 || wb_if.wb_data !== 32'h0000_AAAA || wb_if.wb_reg_d !== 5'd3) begin
            errors++;
            $display("FAIL hold_stable: stall=%b data=%h rd=%0d want 1 0000aaaa 3",
                     stall_req, wb_if.wb_data, wb_if.wb_reg_d);
        end
        wb_if.wb_ready = 1'b1;
        #1;
        checks++;
        if (stall_req !== 1'b0) begin
            errors++;
            $display("FAIL hold_release: stall=%b want 0", stall_req);
        end
        step();
        idle_inputs();
        checks++;
        if (wb_if.wb_valid !== 1'b1 || wb_if.wb_data !== 32'hDEAD_BEEF || wb_if.wb_reg_d !== 5'd9) begin
            errors++;
            $display("FAIL hold_data: valid=%b data=%h rd=%0d want 1 deadbeef 9",
                     wb_if.wb_valid, wb_if.wb_data, wb_if.wb_reg_d);
        end
        step();
        checks++;
        if (wb_if.wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_retire: wb_valid=%b want 0", wb_if.wb_valid);
        end
    endtask

    task automatic test_flush_drain();
        mm2_valid     = 1'b1;
        mm2_mm_re     = 1'b1;
        mm2_reg_d     = 5'd4;
        mm2_reg_d_wen = 1'b1;
        step();
        flush = 1'b1;
        #1;
        checks++;
        if (stall_req !== 1'b0) begin
            errors++;
            $display("FAIL flush_wait_stall: got %b want 0", stall_req);
        end
        step();
        idle_inputs();
        #1;
        checks++;
        if (stall_req !== 1'b1 || wb_if.wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_stall: stall=%b wb_valid=%b want 1 0", stall_req, wb_if.wb_valid);
        end
        step();
        dm_rvalid = 1'b1;
        dm_rdata  = 32'h1111_1111;
        #1;
        checks++;
        if (stall_req !== 1'b1) begin
            errors++;
            $display("FAIL drain_resp_stall: got %b want 1", stall_req);
        end
        step();
        dm_rvalid = 1'b0;
        #1;
        checks++;
        if (stall_req !== 1'b0 || wb_if.wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_exit: stall=%b wb_valid=%b want 0 0", stall_req, wb_if.wb_valid);
        end
        mm2_valid     = 1'b1;
        mm2_exe_out   = 32'h55;
        mm2_reg_d_wen = 1'b1;
        step();
        idle_inputs();
        checks++;
        if (wb_if.wb_valid !== 1'b1 || wb_if.wb_data !== 32'h55) begin
            errors++;
            $display("FAIL post_drain_alu: valid=%b data=%h want 1 00000055",
                     wb_if.wb_valid, wb_if.wb_data);
        end
        step();
    endtask

    task automatic test_excp();
        mm2_valid     = 1'b1;
        mm2_mm_re     = 1'b1;
        mm2_excp      = 1'b1;
        mm2_reg_d     = 5'd6;
        mm2_reg_d_wen = 1'b1;
        mm2_exe_out   = 32'hBAD;
        #1;
        checks++;
        if (stall_req !== 1'b0) begin
            errors++;
            $display("FAIL excp_stall: got %b want 0", stall_req);
        end
        step();
        idle_inputs();
        checks++;
        if (wb_if.wb_valid !== 1'b1 || wb_if.wb_excp !== 1'b1 || wb_if.wb_wen !== 1'b0 ||
            wb_if.wb_data !== 32'hBAD) begin
            errors++;
            $display("FAIL excp_wb: valid=%b excp=%b wen=%b data=%h want 1 1 0 00000bad",
                     wb_if.wb_valid, wb_if.wb_excp, wb_if.wb_wen, wb_if.wb_data);
        end
        step();
    endtask

    task automatic test_flush_keeps_wb();
        wb_if.wb_ready = 1'b0;
        mm2_valid      = 1'b1;
        mm2_exe_out    = 32'h77;
        mm2_reg_d      = 5'd2;
        mm2_reg_d_wen  = 1'b1;
        step();
        flush       = 1'b1;
        mm2_exe_out = 32'h99;
        mm2_reg_d   = 5'd10;
        #1;
        checks++;
        if (stall_req !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle_stall: got %b want 0", stall_req);
        end
        step();
        idle_inputs();
        wb_if.wb_ready = 1'b0;
        checks++;
        if (wb_if.wb_valid !== 1'b1 || wb_if.wb_data !== 32'h77 || wb_if.wb_reg_d !== 5'd2) begin
            errors++;
            $display("FAIL flush_wb_kept: valid=%b data=%h rd=%0d want 1 00000077 2",
                     wb_if.wb_valid, wb_if.wb_data, wb_if.wb_reg_d);
        end
        wb_if.wb_ready = 1'b1;
        step();
        checks++;
        if (wb_if.wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_no_cpl: wb_valid=%b want 0", wb_if.wb_valid);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_byte();
        test_load_wait();
        test_hold();
        test_flush_drain();
        test_excp();
        test_flush_keeps_wb();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
